alu_muldiv_seq: RTL and testbench

- Parametrised, iterative multiply/divide unit implementing the RV32M operation set. It is the multi-cycle companion to the single-cycle integer ALU.
- Takes WIDTH-bit operands through a valid/ready handshake and computes one radix-2 step per cycle.
- Returns the result and NZCV-style status through a second valid/ready handshake.
- Sits beside the ALU in the execute stage; the core stalls while a result is pending.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_muldiv_seq.sv | 186 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the single-cycle ALU and the iterative multiply/divide unit.
// Operation codes follow the RV32M funct3 encoding.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  localparam int STATUS_N = 3;
  localparam int STATUS_Z = 2;
  localparam int STATUS_C = 1;
  localparam int STATUS_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, followed by a single sign-fix cycle.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status,
  output muldiv_state_e    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits for ready, and the producer holds its payload
  // stable while valid is high and ready is low.

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_e      state_q, state_d;
  muldiv_op_e         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         status_q, status_d;

  // Accept-side decode works on the live inputs; everything after uses copies.
  muldiv_op_e       op_in;
  logic             sa_in, sb_in, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a_in, mag_b_in, spec_res;

  assign op_in    = muldiv_op_e'(op);
  assign sa_in    = op_a_signed(op_in) & a[WIDTH-1];
  assign sb_in    = op_b_signed(op_in) & b[WIDTH-1];
  assign mag_a_in = sa_in ? -a : a;
  assign mag_b_in = sb_in ? -b : b;
  assign div_zero = op_is_div(op_in) && (b == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (a == MOST_NEG) && (b == '1);

  always_comb begin
    spec_res = '0;
    if (div_zero)                spec_res = op_is_rem(op_in) ? a : '1;
    else if (!op_is_rem(op_in))  spec_res = a;
  end

  // Iteration datapath: carry-preserving add for the product, WIDTH+1 bit trial subtract.
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  logic           div_ge;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};
  assign div_ge    = div_shift >= {1'b0, mag_b_q};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -quo_q : quo_q;
  assign rem_fix  = neg_q ? -rem_q : rem_q;

  always_comb begin
    fix_res = rem_fix;
    case (op_q)
      OP_MUL:                     fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:            fix_res = quo_fix;
      default:                    fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    status_d  = status_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          op_d    = op_in;
          // Remainder takes the dividend's sign; products and quotients take sa^sb.
          neg_d   = op_is_rem(op_in) ? sa_in : (sa_in ^ sb_in);
          mag_a_d = mag_a_in;
          mag_b_d = mag_b_in;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, mag_b_in};
          rem_d   = '0;
          quo_d   = mag_a_in;
          if (div_zero || div_ovf) begin
            result_d           = spec_res;
            status_d           = '0;
            status_d[STATUS_N] = spec_res[WIDTH-1];
            status_d[STATUS_Z] = (spec_res == '0);
            status_d[STATUS_C] = div_zero;
            status_d[STATUS_V] = div_ovf;
            state_d            = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_is_div(op_q)) begin
          rem_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], div_ge};
        end else if (acc_q[0]) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        if (cnt_q == LAST_STEP) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d           = fix_res;
        status_d           = '0;
        status_d[STATUS_N] = fix_res[WIDTH-1];
        status_d[STATUS_Z] = (fix_res == '0);
        state_d            = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign result    = result_q;
  assign status    = status_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed RV32M vectors against an arithmetic model,
// plus backpressure, mid-operation reset and an 8-bit instance.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    op;
  logic [31:0]   a, b, result;
  logic [3:0]    status;
  muldiv_state_e dbg_state;

  // 8-bit instance
  logic          in_valid8, in_ready8, out_valid8, out_ready8;
  logic [2:0]    op8;
  logic [7:0]    a8, b8, result8;
  logic [3:0]    status8;
  muldiv_state_e dbg_state8;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .status(status), .dbg_state(dbg_state)
  );

  alu_muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .status(status8), .dbg_state(dbg_state8)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [35:0] exp_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: {status, result} ----------------
  function automatic logic [35:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q;
    logic [63:0] p;
    logic [31:0] r;
    logic c, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c = 1'b0; v = 1'b0; r = '0; p = '0; q = 0;
    case (o)
      3'd0: begin p = sx * sy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * longint'({32'd0, y}); r = p[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y}; r = p[63:32]; end
      default: begin
        if (y == 32'd0) begin
          c = 1'b1;
          r = (o == 3'd6 || o == 3'd7) ? x : 32'hFFFF_FFFF;
        end else if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          v = 1'b1;
          r = (o == 3'd4) ? x : 32'd0;
        end else begin
          case (o)
            3'd4:    begin q = sx / sy; r = q[31:0]; end
            3'd5:    r = x / y;
            3'd6:    begin q = sx % sy; r = q[31:0]; end
            default: r = x % y;
          endcase
        end
      end
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("busy_in_ready", in_ready, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", out_valid, 0);
      end else begin
        chk("result", result, exp_q[0][31:0]);
        chk("status", status, exp_q[0][35:32]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at #1 after a rising edge) ----------------
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int lat);
    int edges;
    op = o; a = x; b = y; in_valid = 1'b1;
    chk("accept_ready", in_ready, 1);
    exp_q.push_back(model(o, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    edges = 1;
    while (!out_valid && edges < 200) begin
      chk("calc_in_ready", in_ready, 0);
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, lat);
  endtask

  task automatic drain(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic [3:0]  st;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] r, input logic [3:0] s, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.st = s; v.lat = l;
    vecs.push_back(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int edges;
    in_valid = 0; out_ready = 0; op = 0; a = 0; b = 0;
    in_valid8 = 0; out_ready8 = 0; op8 = 0; a8 = 0; b8 = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_status", status, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    #1;
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;

    add(OP_MUL,    32'd3,          32'd11,         32'd33,         4'b0000, 34);
    add(OP_MULH,   32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  4'b1000, 34);
    add(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  4'b1000, 34);
    add(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  4'b1000, 34);
    add(OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  4'b1000, 34);
    add(OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  4'b1000, 34);
    add(OP_DIVU,   32'd100,        32'd7,          32'd14,         4'b0000, 34);
    add(OP_REMU,   32'd100,        32'd7,          32'd2,          4'b0000, 34);
    add(OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  4'b1010, 1);
    add(OP_REM,    32'd5,          32'd0,          32'd5,          4'b0010, 1);
    add(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  4'b1001, 1);
    add(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          4'b0101, 1);
    add(OP_REMU,   32'd7,          32'd0,          32'd7,          4'b0010, 1);
    add(OP_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  4'b1000, 34);
    add(OP_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  4'b1000, 34);
    add(OP_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          4'b0000, 34);
    add(OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  4'b0000, 34);
    add(OP_MUL,    32'd0,          32'd12345,      32'd0,          4'b0100, 34);
    add(OP_DIV,    32'h8000_0000,  32'd1,          32'h8000_0000,  4'b1000, 34);
    add(OP_DIVU,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  4'b1000, 34);

    foreach (vecs[i]) begin
      chk("model_pin", model(vecs[i].op, vecs[i].a, vecs[i].b), {vecs[i].st, vecs[i].res});
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat);
      drain(i % 3);
    end

    // Backpressure: result held, second request ignored.
    issue(OP_DIVU, 32'd100, 32'd7, 34);
    op = OP_MUL; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    repeat (5) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 32'd14);
      @(posedge clk); #1;
    end
    drain(0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_no_extra", out_valid, 0);
    end
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a computation.
    op = OP_MUL; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    chk("abort_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_status", status, 0);
    chk("abort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_release_ready", in_ready, 1);
    chk("abort_state", dbg_state, ST_IDLE);
    issue(OP_MUL, 32'd3, 32'd11, 34);
    drain(1);

    // 8-bit instance.
    op8 = OP_MUL; a8 = 8'd3; b8 = 8'd11; in_valid8 = 1'b1;
    chk("w8_accept_ready", in_ready8, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
    edges = 1;
    while (!out_valid8 && edges < 100) begin
      chk("w8_calc_in_ready", in_ready8, 0);
      @(posedge clk); #1;
      edges++;
    end
    chk("w8_latency", edges, 10);
    chk("w8_result", result8, 8'd33);
    chk("w8_status", status8, 4'b0000);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("w8_valid_drop", out_valid8, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
